// File: rtl/unit_rate_add_buffered.sv
// Registered constant-increment stage with an elastic FIFO of DEPTH entries.
// Each accepted token is stored as arg0 + STEP (wrapping or saturating) and popped in order.
module unit_rate_add_buffered #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           arg0,
    input  logic                       arg1,
    input  logic                       arg2,
    output logic                       ret0,
    output logic [WIDTH-1:0]           ret1,
    output logic                       ret2,
    output logic [$clog2(DEPTH+1)-1:0] ret3
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic signed [WIDTH:0]   STEP_X  = (WIDTH + 1)'(STEP);
    localparam logic        [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic        [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic        [PW-1:0]    LAST    = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rdPtr;
    logic [PW-1:0]    r_wrPtr;
    logic [CW-1:0]    r_count;

    logic signed [WIDTH:0] w_sum;
    logic [WIDTH-1:0]      w_result;
    logic                  w_ready;
    logic                  w_valid;
    logic                  w_enq;
    logic                  w_deq;
    logic [PW-1:0]         w_rdNext;
    logic [PW-1:0]         w_wrNext;

    // One extra bit keeps the true sum so overflow shows as a disagreement of the top two bits.
    assign w_sum = $signed({arg0[WIDTH-1], arg0}) + STEP_X;

    always_comb begin
        w_result = w_sum[WIDTH-1:0];
        if (SATURATE != 0 && (w_sum[WIDTH] != w_sum[WIDTH-1])) begin
            w_result = w_sum[WIDTH] ? MIN_VAL : MAX_VAL;
        end
    end

    // Ready looks through to arg2 so a full FIFO can take a token in the cycle it pops one.
    assign w_ready  = !reset && ((r_count < CW'(DEPTH)) || arg2);
    assign w_valid  = !reset && (r_count != '0);
    assign w_enq    = arg1 && w_ready;
    assign w_deq    = w_valid && arg2;
    assign w_rdNext = (r_rdPtr == LAST) ? '0 : r_rdPtr + 1'b1;
    assign w_wrNext = (r_wrPtr == LAST) ? '0 : r_wrPtr + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else begin
            if (w_enq) begin
                r_wrPtr <= w_wrNext;
            end
            if (w_deq) begin
                r_rdPtr <= w_rdNext;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem[r_wrPtr] <= w_result;
        end
    end

    assign ret0 = w_ready;
    assign ret2 = w_valid;
    assign ret1 = w_valid ? r_mem[r_rdPtr] : '0;
    assign ret3 = r_count;

endmodule
